gate_drv: RTL and testbench
===========================

Name: gate_drv

Overview:
- Full-bridge gate driver stage directly downstream of the interrupter.
- Consumes the interrupter's mutually exclusive half-cycle commands `in_p` / `in_n` and produces four registered gate signals for an H-bridge.
- Enforces a programmable dead time between conducting diagonals.
- Latches a sticky fault on illegal (overlapping) commands.
- Dead time is programmed over the same data/addr/en register bus that configures the interrupter.

Parameters:
- CLK_MHZ, 100, system clock frequency in MHz (documentation and derived limits only).
- DT_MAX, 255, maximum dead-time value in clock cycles; sets dead-time register width = clog2(DT_MAX+1).
- DT_DEFAULT, 10, dead-time register value after reset.
- ADDR_MAX, 4, maximum bus address; address width = clog2(ADDR_MAX+1).
- ADDR_DT, 3, bus address of the dead-time register.
- ADDR_CLR, 2, bus address of the fault-clear strobe; written data is ignored.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- in_p, in, 1, positive half-cycle command (drives AH+BL).
- in_n, in, 1, negative half-cycle command (drives BH+AL).
- data, in, clog2(DT_MAX+1), register bus write data.
- addr, in, clog2(ADDR_MAX+1), register bus address.
- en, in, 1, register bus write enable (one-cycle strobe).
- gate_ah, out, 1, leg A high-side gate.
- gate_bl, out, 1, leg B low-side gate.
- gate_bh, out, 1, leg B high-side gate.
- gate_al, out, 1, leg A low-side gate.
- fault, out, 1, sticky overlap fault flag.

Behaviour:
- Reset (async assert, sync release):
  - state=OFF, all gates=0, fault=0, dt_reg=DT_DEFAULT, cnt=0.
- Register writes (sampled on posedge clk):
  - en && addr==ADDR_DT loads dt_reg<=data.
  - en && addr==ADDR_CLR issues a clear strobe.
  - A dt_reg write never alters a countdown already in progress; the new value applies from the next DEAD entry.
- All outputs are registered. Gate outputs are a pure decode of state:
  - ON_P: gate_ah=gate_bl=1.
  - ON_N: gate_bh=gate_al=1.
  - All other states: all gates 0.
  - gate_ah&gate_al and gate_bh&gate_bl are never both 1, in any cycle.
- Overlap check has priority over every other transition. In any state except FAULT, in_p&&in_n sampled high gives state=FAULT and fault=1 on the next edge.
- OFF:
  - in_p&&!in_n -> ON_P.
  - in_n&&!in_p -> ON_N.
  - Otherwise stay.
  - Latency from command high to gates high: 1 cycle.
- ON_P:
  - Stay while in_p.
  - On !in_p: if dt_reg==0 -> OFF; else -> DEAD with cnt<=dt_reg.
  - This applies even if in_n rose in the same cycle; there is never a direct ON_P->ON_N transition.
- ON_N: symmetric to ON_P.
- DEAD:
  - Gates 0; cnt decrements each cycle.
  - When cnt==1 -> OFF. DEAD therefore lasts exactly dt_reg cycles.
  - Commands arriving during DEAD are ignored until OFF.
  - Resulting minimum gate-low gap between diagonals = dt_reg+1 cycles (dt_reg+1 cycles when dt_reg==0 is 1 cycle).
- FAULT:
  - Gates 0, fault=1.
  - Stays until a clear strobe arrives while !in_p&&!in_n. Then -> DEAD with cnt<=dt_reg (-> OFF if dt_reg==0), and fault<=0 on the same edge.
  - A clear strobe with any command active is ignored.
- Clear strobe outside FAULT: no effect.
- rst asserted mid-ON or mid-DEAD: gates drop to 0 asynchronously; the countdown is discarded.

Test Plan:
1. Reset, dt_reg=10. in_p high at cycle 5 for 20 cycles -> gate_ah=gate_bl=1 for cycles 6..25 (gates high from 6, low from 26), other gates 0, fault=0.
2. in_p falls at cycle 25, in_n rises at cycle 25 -> DEAD cycles 26..35, OFF at 36, gate_bh=gate_al=1 from cycle 37 (gap 11 cycles).
3. Write dt_reg=3 via ADDR_DT during an active 10-cycle DEAD -> current DEAD still 10 cycles; the next DEAD is 3 cycles. Then write dt_reg=0 -> ON_P->OFF->ON_N gives a 1-cycle gap.
4. in_p and in_n high together for one cycle while in ON_P -> next cycle all gates 0, fault=1. Fault persists after commands drop.
5. Clear strobe while in_n high -> ignored, fault stays 1. Clear strobe with both inputs low -> fault=0, DEAD for dt_reg cycles, then normal operation resumes.
6. rst pulsed asynchronously mid-ON_N (between clock edges) -> all gates 0 immediately; after release, dt_reg=DT_DEFAULT and state=OFF.

Source files
------------

// File: rtl/gate_drv.sv
// Full-bridge gate driver: turns the interrupter's half-cycle commands into four
// registered H-bridge gates with programmable dead time and a sticky overlap fault.
module gate_drv #(
    parameter int unsigned CLK_MHZ    = 100,
    parameter int unsigned DT_MAX     = 255,
    parameter int unsigned DT_DEFAULT = 10,
    parameter int unsigned ADDR_MAX   = 4,
    parameter int unsigned ADDR_DT    = 3,
    parameter int unsigned ADDR_CLR   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_p,
    input  logic                           in_n,
    input  logic [$clog2(DT_MAX+1)-1:0]    data,
    input  logic [$clog2(ADDR_MAX+1)-1:0]  addr,
    input  logic                           en,
    output logic                           gate_ah,
    output logic                           gate_bl,
    output logic                           gate_bh,
    output logic                           gate_al,
    output logic                           fault
);

    localparam int DT_W = $clog2(DT_MAX + 1);
    localparam int AW   = $clog2(ADDR_MAX + 1);

    localparam logic [AW-1:0]   ADDR_DT_C    = AW'(ADDR_DT);
    localparam logic [AW-1:0]   ADDR_CLR_C   = AW'(ADDR_CLR);
    localparam logic [DT_W-1:0] DT_DEFAULT_C = DT_W'(DT_DEFAULT);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_ON_P  = 3'd1;
    localparam logic [2:0] S_ON_N  = 3'd2;
    localparam logic [2:0] S_DEAD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    if (CLK_MHZ == 0 || DT_DEFAULT > DT_MAX || ADDR_DT > ADDR_MAX || ADDR_CLR > ADDR_MAX)
    begin : g_bad_param
        $error("gate_drv: inconsistent parameters");
    end

    logic [2:0]      state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic [DT_W-1:0] dt_reg;
    logic            wr_dt, wr_clr;
    logic            dt_zero;

    assign wr_dt   = en && (addr == ADDR_DT_C);
    assign wr_clr  = en && (addr == ADDR_CLR_C);
    assign dt_zero = (dt_reg == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state != S_FAULT && in_p && in_n) begin
            state_nxt = S_FAULT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (in_p)      state_nxt = S_ON_P;
                    else if (in_n) state_nxt = S_ON_N;
                end
                S_ON_P, S_ON_N: begin
                    if ((state == S_ON_P && !in_p) || (state == S_ON_N && !in_n)) begin
                        state_nxt = dt_zero ? S_OFF : S_DEAD;
                        cnt_nxt   = dt_reg;
                    end
                end
                S_DEAD: begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt <= DT_W'(1)) begin
                        state_nxt = S_OFF;
                        cnt_nxt   = '0;
                    end
                end
                S_FAULT: begin
                    // Recovery goes through a full dead time so a bridge that was
                    // shoot-through commanded never re-enters conduction abruptly.
                    if (wr_clr && !in_p && !in_n) begin
                        state_nxt = dt_zero ? S_OFF : S_DEAD;
                        cnt_nxt   = dt_reg;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_OFF;
            cnt     <= '0;
            dt_reg  <= DT_DEFAULT_C;
            gate_ah <= 1'b0;
            gate_bl <= 1'b0;
            gate_bh <= 1'b0;
            gate_al <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            if (wr_dt) dt_reg <= data;
            // Gates are registered from the next-state decode, so they always
            // equal a decode of the current state with no combinational output.
            gate_ah <= (state_nxt == S_ON_P);
            gate_bl <= (state_nxt == S_ON_P);
            gate_bh <= (state_nxt == S_ON_N);
            gate_al <= (state_nxt == S_ON_N);
            fault   <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_gate_drv.sv
// Self-checking bench for gate_drv: directed scenarios plus randomized commands and
// bus writes, compared each cycle against a behavioural bridge model.
module tb_gate_drv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_p = 1'b0;
    logic       in_n = 1'b0;
    logic [7:0] data = '0;
    logic [2:0] addr = '0;
    logic       en = 1'b0;
    logic       gate_ah, gate_bl, gate_bh, gate_al, fault;

    int n_cmp = 0;
    int n_err = 0;

    // Model: conduction direction (+1 P diagonal, -1 N diagonal, 0 none),
    // remaining dead cycles, fault flag and the programmed dead time.
    int m_dir;
    int m_dead;
    bit m_flt;
    int m_dt;

    gate_drv dut (
        .clk     (clk),
        .rst     (rst),
        .in_p    (in_p),
        .in_n    (in_n),
        .data    (data),
        .addr    (addr),
        .en      (en),
        .gate_ah (gate_ah),
        .gate_bl (gate_bl),
        .gate_bh (gate_bh),
        .gate_al (gate_al),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dir  = 0;
        m_dead = 0;
        m_flt  = 1'b0;
        m_dt   = 10;
    endtask

    task automatic model_step(input bit p, input bit n, input bit e,
                              input int a, input int d);
        bit clr;
        clr = e && (a == 2);
        if (!m_flt && p && n) begin
            m_flt  = 1'b1;
            m_dir  = 0;
            m_dead = 0;
        end else if (m_flt) begin
            if (clr && !p && !n) begin
                m_flt  = 1'b0;
                m_dead = m_dt;
            end
        end else if (m_dir != 0) begin
            if ((m_dir > 0 && !p) || (m_dir < 0 && !n)) begin
                m_dir  = 0;
                m_dead = m_dt;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (p) begin
            m_dir = 1;
        end else if (n) begin
            m_dir = -1;
        end
        if (e && a == 3) m_dt = d;
    endtask

    function automatic logic [4:0] model_out();
        return {m_dir > 0, m_dir > 0, m_dir < 0, m_dir < 0, m_flt};
    endfunction

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic cyc(input logic p, input logic n, input logic e,
                       input logic [2:0] a, input logic [7:0] d);
        in_p = p; in_n = n; en = e; addr = a; data = d;
        @(posedge clk);
        model_step(p, n, e, int'(a), int'(d));
        #1;
        check("outputs", {gate_ah, gate_bl, gate_bh, gate_al, fault}, model_out());
        check("no_shoot", (gate_ah & gate_al) | (gate_bh & gate_bl), 0);
    endtask

    // From ON_P, switch to in_n and count gate-low cycles until gate_bh rises.
    task automatic run_gap(input string tag, input int exp_gap);
        int gap;
        bit seen;
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
            if (gate_bh) begin
                seen = 1'b1;
                break;
            end
            gap++;
        end
        check({tag, "_seen"}, seen, 1'b1);
        check(tag, gap, exp_gap);
    endtask

    task automatic async_rst();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async", {gate_ah, gate_bl, gate_bh, gate_al, fault}, 5'b0);
        in_p = 1'b0; in_n = 1'b0; en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        bit rp, rn, re;
        logic [2:0] ra;
        logic [7:0] rd;
        int r;

        model_reset();
        #1;
        check("rst_out", {gate_ah, gate_bl, gate_bh, gate_al, fault}, 5'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Default dead time: ON_P for 20 cycles, then switch to ON_N.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        check("on_p_gates", {gate_ah, gate_bl, gate_bh, gate_al}, 4'b1100);
        run_gap("gap_dt10", 11);

        // Rewriting dead time mid-countdown only affects the next DEAD.
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 8'd3);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        run_gap("gap_dt3", 4);
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 8'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        run_gap("gap_dt0", 1);

        // Overlap fault, ignored clear with in_n active, then real clear.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        check("fault_set", {gate_ah, gate_bl, gate_bh, gate_al, fault}, 5'b00001);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        cyc(1'b0, 1'b1, 1'b1, 3'd2, 8'd0);
        check("clr_ignored", fault, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 8'd4);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 8'd0);
        check("clr_done", fault, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);

        // Async reset in the middle of ON_N.
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        check("on_n_gates", {gate_ah, gate_bl, gate_bh, gate_al}, 4'b0011);
        async_rst();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        run_gap("gap_after_rst", 11);

        // Randomized commands, overlaps, dead-time writes and clears.
        hold = 0;
        rp = 1'b0;
        rn = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                rp = (r < 35) || (r >= 96);
                rn = (r >= 35 && r < 70) || (r >= 96);
                hold = (rp && rn) ? 1 : $urandom_range(1, 15);
            end
            hold--;
            re = ($urandom_range(0, 9) == 0);
            r  = $urandom_range(0, 9);
            ra = (r < 4) ? 3'd2 : (r < 8) ? 3'd3 : 3'($urandom_range(0, 4));
            rd = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 6));
            cyc(rp, rn, re, ra, rd);
            if (k == 1500 || k == 3100) async_rst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
